// File: rtl/interval_timer.sv
// Interval timer: prescaled base tick plus a loadable down-counter
// with one-shot/periodic modes, pause and abort.
module interval_timer #(
  parameter int TICK_COUNT = 27_000_000,
  parameter int PRESC_W    = 25,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             devider_reset,
  input  logic             sync_clear,
  input  logic             abort,
  input  logic             load,
  input  logic [CNT_W-1:0] duration,
  input  logic             periodic,
  input  logic             pause,
  output logic             tick,
  output logic             expired,
  output logic [CNT_W-1:0] remaining,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } state_t;

  localparam logic [PRESC_W-1:0] LAST = PRESC_W'(TICK_COUNT - 1);

  state_t             state;
  logic [PRESC_W-1:0] presc;
  logic [CNT_W-1:0]   dur_q;
  logic               per_q;
  logic               wrap;
  logic [PRESC_W-1:0] presc_inc;

  assign wrap      = (presc == LAST);
  assign presc_inc = wrap ? '0 : presc + PRESC_W'(1);

  // Prescaler, interval FSM and registered outputs, one edge priority chain
  always_ff @(posedge clk or posedge devider_reset) begin
    if (devider_reset) begin
      state     <= IDLE;
      presc     <= '0;
      dur_q     <= '0;
      per_q     <= 1'b0;
      tick      <= 1'b0;
      expired   <= 1'b0;
      remaining <= '0;
      busy      <= 1'b0;
    end else begin
      tick    <= 1'b0;
      expired <= 1'b0;
      if (abort) begin
        // Cancel silently; the prescaler keeps free-running.
        state     <= IDLE;
        remaining <= '0;
        busy      <= 1'b0;
        presc     <= presc_inc;
        tick      <= wrap;
      end else if (load) begin
        presc <= '0;
        dur_q <= duration;
        per_q <= periodic;
        if (duration == '0) begin
          state     <= IDLE;
          remaining <= '0;
          busy      <= 1'b0;
          expired   <= 1'b1;
        end else begin
          state     <= pause ? HOLD : RUN;
          remaining <= duration;
          busy      <= 1'b1;
        end
      end else if (sync_clear) begin
        presc <= '0;
      end else if (pause && state != IDLE) begin
        // Hold: prescaler and count frozen, no tick.
        state <= HOLD;
      end else begin
        presc <= presc_inc;
        tick  <= wrap;
        if (state != IDLE) begin
          state <= RUN;
          if (wrap) begin
            if (remaining > CNT_W'(1)) begin
              remaining <= remaining - CNT_W'(1);
            end else begin
              expired <= 1'b1;
              if (per_q) begin
                remaining <= dur_q;
              end else begin
                remaining <= '0;
                state     <= IDLE;
                busy      <= 1'b0;
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_interval_timer.sv
// Directed bench for interval_timer with TICK_COUNT=4, CNT_W=4.
// Observed vector is {tick, expired, busy, remaining}.
module tb_interval_timer;

  logic       clk = 1'b0;
  logic       devider_reset;
  logic       sync_clear;
  logic       abort;
  logic       load;
  logic [3:0] duration;
  logic       periodic;
  logic       pause;
  logic       tick;
  logic       expired;
  logic [3:0] remaining;
  logic       busy;

  int passed = 0;
  int total  = 0;

  interval_timer #(
    .TICK_COUNT(4),
    .PRESC_W(2),
    .CNT_W(4)
  ) dut (
    .clk(clk),
    .devider_reset(devider_reset),
    .sync_clear(sync_clear),
    .abort(abort),
    .load(load),
    .duration(duration),
    .periodic(periodic),
    .pause(pause),
    .tick(tick),
    .expired(expired),
    .remaining(remaining),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] exp);
    logic [6:0] got;
    got = {tick, expired, busy, remaining};
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  task automatic chk3(input string tag, input logic [5:0] exp);
    logic [5:0] got;
    got = {expired, busy, remaining};
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %b expected %b", tag, got, exp);
  endtask

  initial begin
    devider_reset = 1'b1;
    sync_clear    = 1'b0;
    abort         = 1'b0;
    load          = 1'b0;
    duration      = 4'd0;
    periodic      = 1'b0;
    pause         = 1'b0;
    #3;
    chk("reset_hold", 7'b0);
    #9;
    devider_reset = 1'b0;
    chk("reset_release", 7'b0);

    // Free-running tick: pulse after every 4th edge
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("free_tick", {k % 4 == 0, 1'b0, 1'b0, 4'd0});
    end

    // One-shot D=3
    load = 1'b1; duration = 4'd3; periodic = 1'b0;
    step();
    load = 1'b0;
    chk("os_load", {1'b0, 1'b0, 1'b1, 4'd3});
    for (int k = 1; k <= 13; k++) begin
      step();
      chk("oneshot", {k % 4 == 0 && k <= 12, k == 12, k < 12,
                      4'(k < 4 ? 3 : k < 8 ? 2 : k < 12 ? 1 : 0)});
    end

    // Periodic D=2
    load = 1'b1; duration = 4'd2; periodic = 1'b1;
    step();
    load = 1'b0;
    chk("per_load", {1'b0, 1'b0, 1'b1, 4'd2});
    for (int k = 1; k <= 24; k++) begin
      step();
      chk("periodic", {k % 4 == 0, k % 8 == 0, 1'b1,
                       4'(k % 8 < 4 ? 2 : 1)});
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("per_abort", 7'b0);

    // One-shot D=3 with pause sampled on edges E0+5..E0+10
    load = 1'b1; duration = 4'd3; periodic = 1'b0;
    step();
    load = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      int j;
      step();
      j = k <= 4 ? k : k <= 10 ? 4 : k - 6;
      chk("pause", {(k <= 4 || k > 10) && j % 4 == 0, j == 12, j < 12,
                    4'(j < 4 ? 3 : j < 8 ? 2 : j < 12 ? 1 : 0)});
      if (k == 4) pause = 1'b1;
      if (k == 10) pause = 1'b0;
    end

    // sync_clear at E0+2 shifts the first decrement to E0+6
    load = 1'b1; duration = 4'd3;
    step();
    load = 1'b0;
    chk("sc_load", {1'b0, 1'b0, 1'b1, 4'd3});
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("sync_clear", {k == 6, 1'b0, 1'b1, 4'(k < 6 ? 3 : 2)});
      sync_clear = (k == 1);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk3("sc_abort", 6'b0);

    // Zero-length load expires immediately
    load = 1'b1; duration = 4'd0;
    step();
    load = 1'b0;
    chk("zero_load", {1'b0, 1'b1, 1'b0, 4'd0});
    step();
    chk3("zero_after", 6'b0);

    // abort beats load
    load = 1'b1; abort = 1'b1; duration = 4'd3;
    step();
    load = 1'b0; abort = 1'b0;
    chk3("abort_load", 6'b0);
    step();
    chk3("abort_load2", 6'b0);

    // Reload D=5 while D=3 runs
    load = 1'b1; duration = 4'd3;
    step();
    load = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("pre_reload", {k == 4, 1'b0, 1'b1, 4'(k < 4 ? 3 : 2)});
    end
    load = 1'b1; duration = 4'd5;
    step();
    load = 1'b0;
    chk("reload", {1'b0, 1'b0, 1'b1, 4'd5});
    for (int m = 1; m <= 20; m++) begin
      step();
      chk("reload_run", {m % 4 == 0, m == 20, m < 20, 4'(5 - m / 4)});
    end

    // Asynchronous reset mid-interval
    load = 1'b1; duration = 4'd3;
    step();
    load = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk("pre_rst", {k == 4, 1'b0, 1'b1, 4'(k < 4 ? 3 : 2)});
    end
    #2;
    devider_reset = 1'b1;
    #1;
    chk("async_rst", 7'b0);
    devider_reset = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      step();
      chk("post_rst", {n == 4, 1'b0, 1'b0, 4'd0});
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
